// File: rtl/tdm_demux16_pkg.sv
// Shared constants and state type for the 16-lane TDM receive path.
package tdm_demux16_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned SLOT_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  function automatic logic [LANES-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    slot_onehot    = '0;
    slot_onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Slot tracking, sync handling and frame handshake for the TDM demux;
// emits a one-hot lane write-enable for the lane register bank.
module tdm_slot_ctrl
  import tdm_demux16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic              frame_ready,
  output logic              in_ready,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err,
  output logic [LANES-1:0]  lane_we
);

  state_e            r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic              r_sync_err, w_sync_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FILL;
      r_slot     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_sync_err_nxt = 1'b0;
    lane_we        = '0;
    in_ready       = 1'b0;
    frame_valid    = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_sync) begin
            // Resync always lands on lane 0; stale lanes get overwritten as the frame refills.
            lane_we        = slot_onehot('0);
            w_slot_nxt     = SLOT_W'(1);
            w_sync_err_nxt = (r_slot != '0);
          end else begin
            lane_we    = slot_onehot(r_slot);
            w_slot_nxt = r_slot + SLOT_W'(1);
            if (r_slot == '1) w_state_nxt = FULL;
          end
        end
      end
      FULL: begin
        frame_valid = 1'b1;
        if (frame_ready) w_state_nxt = FILL;
      end
    endcase
  end

  assign slot     = r_slot;
  assign sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux16.sv
// Receive end of a 16-lane TDM link: rebuilds parallel lanes from the
// serialized word stream and presents each frame with valid/ready.
module tdm_demux16
  import tdm_demux16_pkg::*;
#(
  parameter int unsigned SIZE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic              in_ready,
  output logic [SIZE-1:0]   out0,
  output logic [SIZE-1:0]   out1,
  output logic [SIZE-1:0]   out2,
  output logic [SIZE-1:0]   out3,
  output logic [SIZE-1:0]   out4,
  output logic [SIZE-1:0]   out5,
  output logic [SIZE-1:0]   out6,
  output logic [SIZE-1:0]   out7,
  output logic [SIZE-1:0]   out8,
  output logic [SIZE-1:0]   out9,
  output logic [SIZE-1:0]   out10,
  output logic [SIZE-1:0]   out11,
  output logic [SIZE-1:0]   out12,
  output logic [SIZE-1:0]   out13,
  output logic [SIZE-1:0]   out14,
  output logic [SIZE-1:0]   out15,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err
);

  logic [LANES-1:0] w_lane_we;
  logic [SIZE-1:0]  r_lane [LANES];

  tdm_slot_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .frame_ready (frame_ready),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err),
    .lane_we     (w_lane_we)
  );

  // Lane bank: the inverse of the sender's mux16 select decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) r_lane[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++)
        if (w_lane_we[i]) r_lane[i] <= in_data;
    end
  end

  assign out0  = r_lane[0];
  assign out1  = r_lane[1];
  assign out2  = r_lane[2];
  assign out3  = r_lane[3];
  assign out4  = r_lane[4];
  assign out5  = r_lane[5];
  assign out6  = r_lane[6];
  assign out7  = r_lane[7];
  assign out8  = r_lane[8];
  assign out9  = r_lane[9];
  assign out10 = r_lane[10];
  assign out11 = r_lane[11];
  assign out12 = r_lane[12];
  assign out13 = r_lane[13];
  assign out14 = r_lane[14];
  assign out15 = r_lane[15];

endmodule

// File: tb/tb_tdm_demux16.sv
// Self-checking bench for tdm_demux16 (SIZE=4) against a frame-level reference model.
module tb_tdm_demux16;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_sync = 1'b0;
  logic            frame_ready = 1'b0;
  logic [SIZE-1:0] in_data = '0;
  logic            in_ready, frame_valid, sync_err;
  logic [3:0]      slot;
  logic [SIZE-1:0] dout [16];

  int n_assert = 0;
  int n_fail   = 0;

  logic [SIZE-1:0] m_lane [16];
  int              m_slot;
  bit              m_full;
  bit              m_err;

  tdm_demux16 #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(in_ready),
    .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
    .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7]),
    .out8(dout[8]), .out9(dout[9]), .out10(dout[10]), .out11(dout[11]),
    .out12(dout[12]), .out13(dout[13]), .out14(dout[14]), .out15(dout[15]),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .slot(slot), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_lane[i] = '0;
    m_slot = 0;
    m_full = 1'b0;
    m_err  = 1'b0;
  endtask

  // Frame-level rules applied at each rising edge, using pre-edge state.
  task automatic model_edge();
    m_err = 1'b0;
    if (m_full) begin
      if (frame_ready) m_full = 1'b0;
    end else if (in_valid) begin
      if (in_sync) begin
        m_err     = (m_slot != 0);
        m_lane[0] = in_data;
        m_slot    = 1;
      end else begin
        m_lane[m_slot] = in_data;
        m_slot = (m_slot + 1) % 16;
        if (m_slot == 0) m_full = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] pack_dut();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = dout[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = m_lane[i];
    return v;
  endfunction

  task automatic check_all();
    chk("frame_valid", 64'(frame_valid), 64'(m_full));
    chk("in_ready",    64'(in_ready),    64'(!m_full));
    chk("slot",        64'(slot),        64'(m_slot));
    chk("sync_err",    64'(sync_err),    64'(m_err));
    chk("lanes",       pack_dut(),       pack_model());
  endtask

  task automatic step(input bit v, input bit s, input logic [SIZE-1:0] d, input bit fr);
    in_valid    = v;
    in_sync     = s;
    in_data     = d;
    frame_ready = fr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between edges and check outputs before any clock edge arrives.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [SIZE-1:0] src [16];
  int              sel;
  int              cyc;
  bit              adv;
  bit              seen;

  initial begin
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single frame of 0..F, sync on the first word
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, SIZE'(i), 1'b0);
    chk("t1_fv",    64'(frame_valid), 64'd1);
    chk("t1_lanes", pack_dut(),       64'hFEDCBA9876543210);
    chk("t1_slot",  64'(slot),        64'd0);

    // 2: frame held while new data is offered
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom()), SIZE'($urandom()), 1'b0);
    chk("t2_held", pack_dut(), 64'hFEDCBA9876543210);
    step(1'b1, 1'b0, 4'h3, 1'b1);
    chk("t2_fv",  64'(frame_valid), 64'd0);
    chk("t2_rdy", 64'(in_ready),    64'd1);

    // 3: mid-frame resync after 7 accepts
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, SIZE'($urandom()), 1'b0);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    chk("t3_err",  64'(sync_err), 64'd1);
    chk("t3_out0", 64'(dout[0]),  64'hA);
    chk("t3_slot", 64'(slot),     64'd1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, SIZE'($urandom()), 1'b0);
    chk("t3_fv", 64'(frame_valid), 64'd1);
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // 4: in_valid on alternate cycles
    cyc = 0;
    while (!m_full && cyc < 64) begin
      step(cyc % 2 == 0, 1'b0, SIZE'($urandom()), 1'b0);
      cyc++;
    end
    chk("t4_cycles", 64'(cyc), 64'd31);
    step(1'b0, 1'b0, 4'h0, 1'b1);

    // 5: async reset mid-FILL (slot 9), then while FULL
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, SIZE'($urandom()), 1'b0);
    chk("t5_slot9", 64'(slot), 64'd9);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, SIZE'($urandom()), 1'b0);
    chk("t5_full", 64'(frame_valid), 64'd1);
    async_reset();

    // 6: mux16 sender with a rolling 4-bit select, consumer always ready
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) src[i] = SIZE'($urandom());
      sel  = 0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
        adv = in_ready;
        step(1'b1, sel == 0, src[sel], 1'b1);
        if (adv) sel = (sel + 1) % 16;
        cyc++;
        seen = m_full;
      end
      chk("t6_seen",   64'(seen),        64'd1);
      chk("t6_period", 64'(cyc),         (f == 0) ? 64'd16 : 64'd17);
      for (int i = 0; i < 16; i++) chk("t6_lane", 64'(dout[i]), 64'(src[i]));
    end

    // Random traffic with occasional resyncs and back-pressure
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
           SIZE'($urandom()), 1'($urandom()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
